// File: rtl/wb_pkg.sv
// Wishbone B4 cycle/burst type codes, slave FSM state encoding and the
// burst next-word helper shared by the burst block RAM slave.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2
    } wb_state_e;

    // Wrap modes only advance the low k bits; the aligned block base stays put.
    function automatic logic [31:0] wb_next_index(input logic [31:0] w, input logic [1:0] bte);
        logic [31:0] r;
        r = w;
        case (bte)
            BTE_LINEAR: r       = w + 32'd1;
            BTE_WRAP4:  r[1:0]  = w[1:0] + 2'd1;
            BTE_WRAP8:  r[2:0]  = w[2:0] + 3'd1;
            BTE_WRAP16: r[3:0]  = w[3:0] + 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wishbone_burst_block_ram_if.sv
// Wishbone B4 bus bundle between the system interconnect (master) and the
// burst block RAM (slave).
interface wishbone_burst_block_ram_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 4
);

    logic                       cyc;
    logic                       stb;
    logic                       we;
    logic [ADDRESS_WIDTH-1:0]   addr;
    logic [BUS_WIDTH*8-1:0]     data_i;
    logic [BUS_WIDTH-1:0]       sel;
    logic [2:0]                 cti;
    logic [1:0]                 bte;
    logic                       ack;
    logic                       err;
    logic [BUS_WIDTH*8-1:0]     data_o;

    modport master (
        output cyc, stb, we, addr, data_i, sel, cti, bte,
        input  ack, err, data_o
    );

    modport slave (
        input  cyc, stb, we, addr, data_i, sel, cti, bte,
        output ack, err, data_o
    );

endinterface

// File: rtl/byte_enable_ram.sv
// Single-port read-first block RAM with per-byte write enables and a
// registered, resettable read port.
module byte_enable_ram #(
    parameter int    BYTES     = 4,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [AW-1:0]        i_addr,
    input  logic                 i_rd_en,
    input  logic [BYTES-1:0]     i_wr_sel,
    input  logic [BYTES*8-1:0]   i_wdata,
    output logic [BYTES*8-1:0]   o_rdata
);

    logic [BYTES*8-1:0] r_mem [DEPTH];
    logic [BYTES*8-1:0] r_rdata;

    // NOTE: the storage array has no reset; only the output register does.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (i_wr_sel[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Sampling r_mem in the same edge as the write yields the old word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wishbone_burst_block_ram.sv
// Wishbone B4 registered-feedback slave: classic cycles with one wait state,
// zero-wait incrementing bursts (linear/wrap), ERR on out-of-range words.
module wishbone_burst_block_ram
    import wb_pkg::*;
#(
    parameter int    ADDRESS_WIDTH = 16,
    parameter int    BUS_WIDTH     = 4,
    parameter int    DEPTH         = 1024,
    parameter string RAM_INIT_FILE = ""
) (
    input  logic                       clk,
    input  logic                       rstn,
    wishbone_burst_block_ram_if.slave  s_wb
);

    localparam int OFF    = $clog2(BUS_WIDTH);
    localparam int IDX_W  = ADDRESS_WIDTH - OFF;
    localparam int RAM_AW = $clog2(DEPTH);

    wb_state_e              r_state;
    wb_state_e              w_state_nxt;
    logic                   r_ack;
    logic                   r_err;
    logic                   w_ack_nxt;
    logic                   w_err_nxt;

    logic                   w_req;
    logic [IDX_W-1:0]       w_idx;
    logic [31:0]            w_idx_ext;
    logic [31:0]            w_nxt_idx;
    logic                   w_in_range;
    logic                   w_nxt_in_range;

    logic [RAM_AW-1:0]      w_ram_addr;
    logic                   w_ram_rd;
    logic [BUS_WIDTH-1:0]   w_ram_wsel;
    logic [BUS_WIDTH*8-1:0] w_ram_rdata;

    assign w_req          = s_wb.cyc & s_wb.stb;
    assign w_idx          = IDX_W'(s_wb.addr >> OFF);
    assign w_idx_ext      = 32'(w_idx);
    assign w_nxt_idx      = wb_next_index(w_idx_ext, s_wb.bte);
    assign w_in_range     = w_idx_ext < 32'(DEPTH);
    assign w_nxt_in_range = w_nxt_idx < 32'(DEPTH);

    // NOTE: every combinational output is defaulted first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        w_ram_addr  = w_idx[RAM_AW-1:0];
        w_ram_rd    = 1'b0;
        w_ram_wsel  = '0;

        case (r_state)
            IDLE: begin
                if (w_req && w_in_range) begin
                    w_ram_rd  = 1'b1;
                    w_ack_nxt = 1'b1;
                    case (s_wb.cti)
                        CTI_INCR:                        w_state_nxt = BURST;
                        CTI_CLASSIC, CTI_CONST, CTI_EOB: w_state_nxt = SINGLE;
                        default:                         w_state_nxt = SINGLE;
                    endcase
                end else if (w_req) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = SINGLE;
                end
            end

            SINGLE: begin
                if (w_req && s_wb.we && r_ack) begin
                    w_ram_wsel = s_wb.sel;
                end
                w_ack_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end

            BURST: begin
                if (!w_req) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    if (s_wb.we && w_in_range) begin
                        w_ram_wsel = s_wb.sel;
                    end
                    // Any cycle type other than incrementing closes the burst.
                    if (s_wb.cti != CTI_INCR) begin
                        w_ack_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end else if (!w_nxt_in_range) begin
                        w_ack_nxt   = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = SINGLE;
                    end else if (!s_wb.we) begin
                        w_ram_rd   = 1'b1;
                        w_ram_addr = w_nxt_idx[RAM_AW-1:0];
                    end
                end
            end

            default: begin
                w_ack_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
        end
    end

    byte_enable_ram #(
        .BYTES     (BUS_WIDTH),
        .DEPTH     (DEPTH),
        .INIT_FILE (RAM_INIT_FILE)
    ) u_ram (
        .clk      (clk),
        .rstn     (rstn),
        .i_addr   (w_ram_addr),
        .i_rd_en  (w_ram_rd),
        .i_wr_sel (w_ram_wsel),
        .i_wdata  (s_wb.data_i),
        .o_rdata  (w_ram_rdata)
    );

    assign s_wb.ack    = r_ack;
    assign s_wb.err    = r_err;
    assign s_wb.data_o = w_ram_rdata;

endmodule
